friscv_memfy_wbuf: RTL

Posted-write buffer between the load/store unit (memfy) and the data cache's memfy_* slave port. It decouples memfy stores from dcache write latency by queueing AXI4-lite AW+W pairs in a FIFO. It also blocks reads that hit a pending store (read-after-write), and caps outstanding downstream writes. The B and R channels pass through.

---
 rtl/friscv_memfy_wbuf.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/friscv_memfy_wbuf.sv
// Posted-write buffer between memfy and the dcache memfy_* port: queues AW+W pairs,
// holds reads that hit a pending store, and caps outstanding writes. Macro: FRISCV_WBUF_BYPASS_EN.
module friscv_memfy_wbuf #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned AXI_ADDR_W  = 8,
    parameter int unsigned AXI_ID_W    = 8,
    parameter int unsigned WBUF_DEPTH  = 4,
    parameter int unsigned OSTDREQ_NUM = 4
) (
    input  logic                  aclk,
    input  logic                  arst,
    // upstream (memfy)
    input  logic                  u_awvalid,
    output logic                  u_awready,
    input  logic [AXI_ADDR_W-1:0] u_awaddr,
    input  logic [2:0]            u_awprot,
    input  logic [3:0]            u_awcache,
    input  logic [AXI_ID_W-1:0]   u_awid,
    input  logic                  u_wvalid,
    output logic                  u_wready,
    input  logic [XLEN-1:0]       u_wdata,
    input  logic [XLEN/8-1:0]     u_wstrb,
    output logic                  u_bvalid,
    input  logic                  u_bready,
    output logic [AXI_ID_W-1:0]   u_bid,
    output logic [1:0]            u_bresp,
    input  logic                  u_arvalid,
    output logic                  u_arready,
    input  logic [AXI_ADDR_W-1:0] u_araddr,
    input  logic [2:0]            u_arprot,
    input  logic [3:0]            u_arcache,
    input  logic [AXI_ID_W-1:0]   u_arid,
    output logic                  u_rvalid,
    input  logic                  u_rready,
    output logic [AXI_ID_W-1:0]   u_rid,
    output logic [1:0]            u_rresp,
    output logic [XLEN-1:0]       u_rdata,
    // downstream (dcache)
    output logic                  d_awvalid,
    input  logic                  d_awready,
    output logic [AXI_ADDR_W-1:0] d_awaddr,
    output logic [2:0]            d_awprot,
    output logic [3:0]            d_awcache,
    output logic [AXI_ID_W-1:0]   d_awid,
    output logic                  d_wvalid,
    input  logic                  d_wready,
    output logic [XLEN-1:0]       d_wdata,
    output logic [XLEN/8-1:0]     d_wstrb,
    input  logic                  d_bvalid,
    output logic                  d_bready,
    input  logic [AXI_ID_W-1:0]   d_bid,
    input  logic [1:0]            d_bresp,
    output logic                  d_arvalid,
    input  logic                  d_arready,
    output logic [AXI_ADDR_W-1:0] d_araddr,
    output logic [2:0]            d_arprot,
    output logic [3:0]            d_arcache,
    output logic [AXI_ID_W-1:0]   d_arid,
    input  logic                  d_rvalid,
    output logic                  d_rready,
    input  logic [AXI_ID_W-1:0]   d_rid,
    input  logic [1:0]            d_rresp,
    input  logic [XLEN-1:0]       d_rdata,
    // status
    output logic                  wbuf_empty,
    output logic                  wbuf_full
);

    localparam int unsigned PTR_W  = $clog2(WBUF_DEPTH);
    localparam int unsigned OST_W  = $clog2(OSTDREQ_NUM) + 1;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [2:0]            prot;
        logic [3:0]            cache;
        logic [AXI_ID_W-1:0]   id;
        logic [XLEN-1:0]       data;
        logic [STRB_W-1:0]     strb;
    } entry_t;

    entry_t             mem_q [WBUF_DEPTH];
    entry_t             mem_d [WBUF_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [OST_W-1:0]   ost_cnt_q, ost_cnt_d;

    entry_t             head;
    entry_t             up_entry;
    logic               empty, full, ost_ok;
    logic               fifo_awvalid, fifo_wvalid;
    logic               up_pair, accept, push, pop, bypass;
    logic               aw_hs, w_hs, d_aw_hs, d_b_hs;
    logic [PTR_W:0]     used;
    logic [PTR_W-1:0]   rel;
    logic               hit;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign used  = wr_ptr_q - rd_ptr_q;

    assign wbuf_empty = empty;
    assign wbuf_full  = full;

    assign head   = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign ost_ok = (ost_cnt_q < OST_W'(OSTDREQ_NUM));

    assign up_entry = '{addr: u_awaddr, prot: u_awprot, cache: u_awcache,
                        id: u_awid, data: u_wdata, strb: u_wstrb};

    assign up_pair = u_awvalid & u_wvalid;
    assign accept  = up_pair & ~full;

`ifdef FRISCV_WBUF_BYPASS_EN
    // Empty buffer and an idle, ready dcache: forward the pair in the same cycle.
    assign bypass = empty & ~aw_done_q & ~w_done_q & ost_ok & d_awready & d_wready & up_pair;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;

    assign u_awready = accept;
    assign u_wready  = accept;

    assign fifo_awvalid = ~empty & ~aw_done_q & ost_ok;
    assign fifo_wvalid  = ~empty & ~w_done_q;

    assign d_awvalid = bypass | fifo_awvalid;
    assign d_wvalid  = bypass | fifo_wvalid;
    assign d_awaddr  = bypass ? up_entry.addr  : head.addr;
    assign d_awprot  = bypass ? up_entry.prot  : head.prot;
    assign d_awcache = bypass ? up_entry.cache : head.cache;
    assign d_awid    = bypass ? up_entry.id    : head.id;
    assign d_wdata   = bypass ? up_entry.data  : head.data;
    assign d_wstrb   = bypass ? up_entry.strb  : head.strb;

    assign aw_hs   = fifo_awvalid & d_awready;
    assign w_hs    = fifo_wvalid & d_wready;
    assign d_aw_hs = d_awvalid & d_awready;
    assign d_b_hs  = d_bvalid & u_bready;

    // Head retires once both of its channels have handshaked, in either order.
    assign pop = ~empty & (aw_done_q | aw_hs) & (w_done_q | w_hs);

    // Read-after-write hazard: any buffered store to the same word blocks the read.
    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
            if (({1'b0, rel} < used) &&
                (mem_q[i].addr[AXI_ADDR_W-1:2] == u_araddr[AXI_ADDR_W-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign d_arvalid = u_arvalid & ~hit;
    assign u_arready = d_arready & ~hit;
    assign d_araddr  = u_araddr;
    assign d_arprot  = u_arprot;
    assign d_arcache = u_arcache;
    assign d_arid    = u_arid;

    assign u_bvalid = d_bvalid;
    assign u_bid    = d_bid;
    assign u_bresp  = d_bresp;
    assign d_bready = u_bready;

    assign u_rvalid = d_rvalid;
    assign u_rid    = d_rid;
    assign u_rresp  = d_rresp;
    assign u_rdata  = d_rdata;
    assign d_rready = u_rready;

    // Next-state for storage, pointers, handshake flags and outstanding count.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        ost_cnt_d = ost_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = up_entry;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end

        case ({d_aw_hs, d_b_hs})
            2'b10:   ost_cnt_d = ost_cnt_q + OST_W'(1);
            2'b01:   ost_cnt_d = ost_cnt_q - OST_W'(1);
            default: ost_cnt_d = ost_cnt_q;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ost_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ost_cnt_q <= ost_cnt_d;
        end
    end

endmodule
